// File: rtl/instr_issue_unit_pkg.sv
// rtl/instr_issue_unit_pkg.sv - shared opcodes, field positions and FSM states for instruction issue
package instr_issue_unit_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } issue_state_t;

    // Anything above OR (other than HALT, which is handled separately) is screened out.
    function automatic logic op_is_legal(input logic [4:0] op);
        return (op <= OP_OR);
    endfunction

endpackage

// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - fetches, screens and issues 16-bit instructions with valid/ready
module instr_issue_unit
    import instr_issue_unit_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    output logic [ADDR_W-1:0]     out_imem_addr,
    output logic                  out_imem_rd_en,
    input  logic [INSTR_W-1:0]    in_imem_data,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [4:0]            out_op_code,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic [REG_ADDR_W-1:0] out_rs1_addr,
    output logic [REG_ADDR_W-1:0] out_rs2_addr,
    output logic [ADDR_W-1:0]     out_pc,
    output logic                  out_halted,
    output logic                  out_illegal
);

    issue_state_t          r_state;
    issue_state_t          w_next_state;
    logic [ADDR_W-1:0]     r_pc;
    logic [4:0]            r_op_code;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic                  r_illegal;

    logic [4:0]            w_opc;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic                  w_is_halt;
    logic                  w_is_legal;
    logic [1:0]            w_unused_bits;

    assign w_opc         = in_imem_data[OPC_MSB:OPC_LSB];
    assign w_rd          = REG_ADDR_W'(in_imem_data[RD_MSB:RD_LSB]);
    assign w_rs1         = REG_ADDR_W'(in_imem_data[RS1_MSB:RS1_LSB]);
    assign w_rs2         = REG_ADDR_W'(in_imem_data[RS2_MSB:RS2_LSB]);
    assign w_unused_bits = in_imem_data[1:0];
    assign w_is_halt     = (w_opc == OP_HALT);
    assign w_is_legal    = op_is_legal(w_opc);

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: one fetch cycle, one memory wait cycle, then hold in ISSUE until accepted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (in_start) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = w_is_halt ? ST_HALT : ST_ISSUE;
            ST_ISSUE: if (in_ready) w_next_state = ST_FETCH;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Issue register capture at the end of WAIT; illegal opcodes become a zeroed NOP.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_op_code <= OP_NOP;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_illegal <= 1'b0;
        end else if (r_state == ST_WAIT && !w_is_halt) begin
            if (w_is_legal) begin
                r_op_code <= w_opc;
                r_rd      <= w_rd;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
            end else begin
                r_op_code <= OP_NOP;
                r_rd      <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_illegal <= 1'b1;
            end
        end
    end

    // Program counter advances only on an accepted issue; a halt leaves it on the halt address.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_pc <= '0;
        end else if (r_state == ST_ISSUE && in_ready) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign out_imem_addr  = r_pc;
    assign out_imem_rd_en = (r_state == ST_FETCH);
    assign out_valid      = (r_state == ST_ISSUE);
    assign out_halted     = (r_state == ST_HALT);
    assign out_op_code    = r_op_code;
    assign out_rd_addr    = r_rd;
    assign out_rs1_addr   = r_rs1;
    assign out_rs2_addr   = r_rs2;
    assign out_pc         = r_pc;
    assign out_illegal    = r_illegal;

endmodule
